// File: rtl/ob_readback_ctrl.sv
// ob_readback_ctrl
// Reads result rows out of the output-buffer SRAM after a matrix job and
// serializes each row into WIDTH-bit elements on a valid/ready stream.
// busy_o lets the top level hand OB port ownership to this block.
//
// Stream handshake: an element transfers on a rising clk_i edge where both
// rd_valid_o and rd_ready_i are high. Once rd_valid_o is high, rd_data_o,
// rd_col_o and rd_last_o hold steady until that transfer, and rd_valid_o
// only falls after a transfer (or on reset). rd_ready_i may lead rd_valid_o.
module ob_readback_ctrl #(
    parameter  int WIDTH  = 8,
    parameter  int COL    = 4,
    parameter  int O_SIZE = 256,
    localparam int AW     = $clog2(O_SIZE),
    localparam int CW     = (COL > 1) ? $clog2(COL) : 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_async_i,
    input  logic                 start_i,
    input  logic [AW-1:0]        base_addr_i,
    input  logic [AW-1:0]        num_rows_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ob_mem_cenb_o,
    output logic                 ob_mem_wenb_o,
    output logic [AW-1:0]        ob_mem_addr_o,
    input  logic [COL*WIDTH-1:0] ob_mem_data_i,
    output logic [WIDTH-1:0]     rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [CW-1:0]        rd_col_o,
    output logic                 rd_last_o,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [CW-1:0] ELEM_LAST = CW'(COL - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(O_SIZE - 1);

    state_t                 state;
    logic [AW-1:0]          num_rows_q;
    logic [AW-1:0]          row_cnt;
    logic [COL*WIDTH-1:0]   row_reg;
    logic [WIDTH-1:0]       row_words [COL];
    logic [CW-1:0]          elem_nxt;
    logic                   last_row;
    logic                   hs;

    // The OB port is only ever read from this block.
    assign ob_mem_wenb_o = 1'b1;
    assign dbg_state_o   = state;

    assign elem_nxt = rd_col_o + CW'(1);
    assign last_row = (row_cnt == num_rows_q);
    assign hs       = rd_valid_o & rd_ready_i;

    // Split the captured row into elements, element 0 in the LSBs.
    always_comb begin
        for (int i = 0; i < COL; i++) begin
            row_words[i] = row_reg[i*WIDTH +: WIDTH];
        end
    end

    // Readback sequencer: READ issues one SRAM read, CAPT latches the row,
    // SEND streams its elements; all outputs are registered here.
    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            state         <= ST_IDLE;
            num_rows_q    <= '0;
            row_cnt       <= '0;
            row_reg       <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            ob_mem_cenb_o <= 1'b1;
            ob_mem_addr_o <= '0;
            rd_data_o     <= '0;
            rd_valid_o    <= 1'b0;
            rd_col_o      <= '0;
            rd_last_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        num_rows_q    <= num_rows_i;
                        ob_mem_addr_o <= base_addr_i;
                        row_cnt       <= '0;
                        ob_mem_cenb_o <= 1'b0;
                        busy_o        <= 1'b1;
                        state         <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Read data shows up on the port during CAPT.
                    ob_mem_cenb_o <= 1'b1;
                    state         <= ST_CAPT;
                end
                ST_CAPT: begin
                    row_reg    <= ob_mem_data_i;
                    rd_data_o  <= ob_mem_data_i[WIDTH-1:0];
                    rd_col_o   <= '0;
                    rd_valid_o <= 1'b1;
                    rd_last_o  <= (ELEM_LAST == '0) && last_row;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (hs) begin
                        if (rd_col_o != ELEM_LAST) begin
                            rd_col_o  <= elem_nxt;
                            rd_data_o <= row_words[elem_nxt];
                            rd_last_o <= (elem_nxt == ELEM_LAST) && last_row;
                        end else begin
                            rd_valid_o <= 1'b0;
                            rd_last_o  <= 1'b0;
                            if (last_row) begin
                                done_o <= 1'b1;
                                state  <= ST_DONE;
                            end else begin
                                row_cnt       <= row_cnt + AW'(1);
                                // Wrap explicitly so a non power-of-two depth still works.
                                ob_mem_addr_o <= (ob_mem_addr_o == ADDR_LAST) ? '0
                                                 : ob_mem_addr_o + AW'(1);
                                ob_mem_cenb_o <= 1'b0;
                                state         <= ST_READ;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ob_readback_ctrl.sv
// Bench for ob_readback_ctrl: an OB SRAM model feeds the DUT, and a reference
// model built from the OB image predicts the element stream and read addresses.
module tb_ob_readback_ctrl;

    localparam int WIDTH  = 8;
    localparam int COL    = 4;
    localparam int O_SIZE = 256;
    localparam int AW     = 8;
    localparam int CW     = 2;
    localparam int DW     = COL * WIDTH;

    logic            clk_i;
    logic            rstn_async_i;
    logic            start_i;
    logic [AW-1:0]   base_addr_i;
    logic [AW-1:0]   num_rows_i;
    logic            busy_o;
    logic            done_o;
    logic            ob_mem_cenb_o;
    logic            ob_mem_wenb_o;
    logic [AW-1:0]   ob_mem_addr_o;
    logic [DW-1:0]   ob_mem_data_i;
    logic [WIDTH-1:0] rd_data_o;
    logic            rd_valid_o;
    logic            rd_ready_i;
    logic [CW-1:0]   rd_col_o;
    logic            rd_last_o;
    logic [2:0]      dbg_state_o;

    ob_readback_ctrl #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
        .clk_i         (clk_i),
        .rstn_async_i  (rstn_async_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_rows_i    (num_rows_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .ob_mem_cenb_o (ob_mem_cenb_o),
        .ob_mem_wenb_o (ob_mem_wenb_o),
        .ob_mem_addr_o (ob_mem_addr_o),
        .ob_mem_data_i (ob_mem_data_i),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .rd_col_o      (rd_col_o),
        .rd_last_o     (rd_last_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cycle_cnt = 0;
    always @(posedge clk_i) cycle_cnt++;

    // ---------------- OB SRAM model ----------------
    // Registered read; junk on the port when not enabled.
    logic [DW-1:0] ob_mem [O_SIZE];
    always @(posedge clk_i) begin
        if (!ob_mem_cenb_o) ob_mem_data_i <= ob_mem[ob_mem_addr_o];
        else                ob_mem_data_i <= DW'($urandom);
    end

    // ---------------- scoreboard state ----------------
    logic [10:0]   exp_q[$];       // {last, col, data}
    logic [AW-1:0] exp_addr_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int start_cyc, done_cyc, done_cnt, cenb_cnt, hs_cnt;
    bit first_pending, prev_valid, prev_hs;
    logic [WIDTH-1:0] prev_data;
    logic [CW-1:0]    prev_col;
    logic             prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle_cnt);
        end
    endtask

    // Reference model: rows base..base+num mod depth, elements LSB first.
    task automatic push_job(input int base, input int num);
        int row;
        logic [DW-1:0] word;
        logic [7:0] dv;
        logic [1:0] cv;
        logic lv;
        for (int r = 0; r <= num; r++) begin
            row = (base + r) % O_SIZE;
            exp_addr_q.push_back(AW'(row));
            word = ob_mem[row];
            for (int c = 0; c < COL; c++) begin
                dv = 8'((word >> (WIDTH * c)) & 32'hff);
                cv = 2'(c);
                lv = (r == num) && (c == COL - 1);
                exp_q.push_back({lv, cv, dv});
            end
        end
    endtask

    // Monitor, called once per cycle at the falling edge.
    task automatic sample();
        logic [10:0] e;
        bit hs;
        if (!ob_mem_cenb_o) begin
            cenb_cnt++;
            check("wenb_high", ob_mem_wenb_o, 1);
            check("cenb_expected", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) check("cenb_addr", ob_mem_addr_o, exp_addr_q.pop_front());
        end
        if (prev_valid && !prev_hs) begin
            check("valid_hold", rd_valid_o, 1);
            check("data_hold", rd_data_o, prev_data);
            check("col_hold", rd_col_o, prev_col);
            check("last_hold", rd_last_o, prev_last);
        end
        if (rd_valid_o && first_pending) begin
            check("first_valid_lat", cycle_cnt - start_cyc, 3);
            first_pending = 0;
        end
        hs = rd_valid_o && rd_ready_i;
        if (hs) begin
            hs_cnt++;
            check("elem_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data", rd_data_o, e[7:0]);
                check("col", rd_col_o, e[9:8]);
                check("last", rd_last_o, e[10]);
            end
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cycle_cnt;
            check("busy_at_done", busy_o, 1);
            check("elems_left_at_done", exp_q.size(), 0);
        end
        prev_valid = rd_valid_o;
        prev_hs    = hs;
        prev_data  = rd_data_o;
        prev_col   = rd_col_o;
        prev_last  = rd_last_o;
    endtask

    // Advance one cycle: sample at the falling edge, return 1 unit after the rising edge.
    task automatic next_cycle();
        @(negedge clk_i);
        sample();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cenb", ob_mem_cenb_o, 1);
        check("rst_wenb", ob_mem_wenb_o, 1);
        check("rst_addr", ob_mem_addr_o, 0);
        check("rst_valid", rd_valid_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_col", rd_col_o, 0);
        check("rst_last", rd_last_o, 0);
        check("rst_state", dbg_state_o, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_job(input int base, input int num, input bit rnd, input bit inject);
        int d0, c0, limit;
        bit got;
        push_job(base, num);
        d0 = done_cnt;
        c0 = cenb_cnt;
        rd_ready_i    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start_i       = 1'b1;
        base_addr_i   = AW'(base);
        num_rows_i    = AW'(num);
        start_cyc     = cycle_cnt;
        first_pending = 1;
        next_cycle();
        start_i     = 1'b0;
        base_addr_i = AW'($urandom);
        num_rows_i  = AW'($urandom);
        check("busy_after_start", busy_o, 1);
        rd_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        limit = rnd ? (num + 1) * (COL + 2) * 20 + 40 : (num + 1) * (COL + 2) + 20;
        got = 0;
        for (int k = 0; k < limit && !got; k++) begin
            next_cycle();
            if (done_cnt != d0) begin
                got = 1;
            end else begin
                rd_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (inject && rd_valid_o && $urandom_range(0, 3) == 0) begin
                    start_i     = 1'b1;
                    base_addr_i = AW'($urandom);
                    num_rows_i  = AW'($urandom);
                end else begin
                    start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        check("done_seen", got, 1);
        if (!rnd) check("done_latency", done_cyc - start_cyc, (num + 1) * (COL + 2) + 1);
        check("cenb_pulses", cenb_cnt - c0, num + 1);
        check("elems_left", exp_q.size(), 0);
        check("addrs_left", exp_addr_q.size(), 0);
        repeat (3) next_cycle();
        check("busy_after_done", busy_o, 0);
        check("done_once", done_cnt - d0, 1);
        exp_q.delete();
        exp_addr_q.delete();
        first_pending = 0;
    endtask

    task automatic reset_mid_send();
        int h0;
        bit reached;
        for (int i = 0; i < 4; i++) ob_mem[i] = DW'($urandom);
        push_job(0, 3);
        rd_ready_i    = 1'b1;
        start_i       = 1'b1;
        base_addr_i   = '0;
        num_rows_i    = AW'(3);
        start_cyc     = cycle_cnt;
        first_pending = 1;
        next_cycle();
        start_i = 1'b0;
        h0 = hs_cnt;
        reached = 0;
        for (int k = 0; k < 40 && !reached; k++) begin
            next_cycle();
            if (hs_cnt - h0 >= 5 && rd_valid_o) reached = 1;
        end
        check("reset_reached_send", reached, 1);
        #2;
        rstn_async_i = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_addr_q.delete();
        first_pending = 0;
        prev_valid    = 0;
        prev_hs       = 0;
        @(posedge clk_i);
        #1;
        rstn_async_i = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b, n;
        bit r, inj;
        for (int i = 0; i < O_SIZE; i++) ob_mem[i] = DW'($urandom);
        rstn_async_i = 1'b0;
        start_i      = 1'b0;
        base_addr_i  = '0;
        num_rows_i   = '0;
        rd_ready_i   = 1'b0;
        done_cnt = 0; cenb_cnt = 0; hs_cnt = 0;
        start_cyc = 0; done_cyc = 0;
        first_pending = 0; prev_valid = 0; prev_hs = 0;
        prev_data = '0; prev_col = '0; prev_last = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs();
        rstn_async_i = 1'b1;
        next_cycle();

        // Abort mid-row, then a normal job on the same rows.
        reset_mid_send();
        run_job(0, 3, 0, 0);

        // Single known row.
        ob_mem[0] = 32'h44332211;
        run_job(0, 0, 0, 0);

        // Two rows under random backpressure.
        run_job($urandom_range(0, 254), 1, 1, 0);

        // Address wrap past the top of the buffer.
        run_job(254, 3, 0, 0);
        run_job(254, 3, 1, 0);

        // Starts pulsed while streaming must be ignored.
        run_job($urandom_range(0, 255), 2, 1, 1);

        // Assorted random jobs.
        for (int j = 0; j < 4; j++) begin
            b   = $urandom_range(0, 255);
            n   = $urandom_range(0, 5);
            r   = 1'($urandom_range(0, 1));
            inj = 1'($urandom_range(0, 1));
            run_job(b, n, r, inj);
        end

        // Whole buffer.
        run_job(0, 255, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
